count_display_driver: RTL and testbench

- Downstream consumer of the 8-bit up/down counter output.
- Converts the unsigned count to 3 BCD digits with a sequential double-dabble engine.
- Drives a 4-digit multiplexed common-anode 7-segment display: ones, tens, hundreds, and a direction glyph ('U' up / 'd' down).
- Sits between the counter and the board's segment and anode pins.

---
 rtl/count_display_driver_pkg.sv | 58 +++++
 rtl/count_display_driver_bin2bcd_seq.sv | 88 ++++++++
 rtl/count_display_driver.sv | 94 +++++++++
 tb/tb_count_display_driver.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/count_display_driver_pkg.sv
// Shared types, widths and 7-segment glyphs for the count display driver.
package count_display_driver_pkg;

   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned BIN_W      = 8;
   localparam int unsigned BCD_W      = 12;
   localparam int unsigned BCD_DIGITS = 3;
   localparam int unsigned SR_W       = BCD_W + BIN_W;
   localparam int unsigned ITER_W     = $clog2(BIN_W);
   localparam int unsigned SEG_W      = 7;
   localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } conv_state_e;

   typedef struct packed {
      logic [3:0] hundreds;
      logic [3:0] tens;
      logic [3:0] ones;
   } bcd_t;

   // Active-low segments, ordered {g,f,e,d,c,b,a}
   localparam logic [SEG_W-1:0] GLYPH_0     = 7'b1000000;
   localparam logic [SEG_W-1:0] GLYPH_1     = 7'b1111001;
   localparam logic [SEG_W-1:0] GLYPH_2     = 7'b0100100;
   localparam logic [SEG_W-1:0] GLYPH_3     = 7'b0110000;
   localparam logic [SEG_W-1:0] GLYPH_4     = 7'b0011001;
   localparam logic [SEG_W-1:0] GLYPH_5     = 7'b0010010;
   localparam logic [SEG_W-1:0] GLYPH_6     = 7'b0000010;
   localparam logic [SEG_W-1:0] GLYPH_7     = 7'b1111000;
   localparam logic [SEG_W-1:0] GLYPH_8     = 7'b0000000;
   localparam logic [SEG_W-1:0] GLYPH_9     = 7'b0010000;
   localparam logic [SEG_W-1:0] GLYPH_U     = 7'b1000001;
   localparam logic [SEG_W-1:0] GLYPH_D     = 7'b0100001;
   localparam logic [SEG_W-1:0] GLYPH_BLANK = 7'b1111111;

   function automatic logic [SEG_W-1:0] glyph_of(input logic [3:0] nib);
      logic [SEG_W-1:0] g;
      case (nib)
         4'd0:    g = GLYPH_0;
         4'd1:    g = GLYPH_1;
         4'd2:    g = GLYPH_2;
         4'd3:    g = GLYPH_3;
         4'd4:    g = GLYPH_4;
         4'd5:    g = GLYPH_5;
         4'd6:    g = GLYPH_6;
         4'd7:    g = GLYPH_7;
         4'd8:    g = GLYPH_8;
         4'd9:    g = GLYPH_9;
         default: g = GLYPH_BLANK;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/count_display_driver_bin2bcd_seq.sv
// Sequential double-dabble: 8-bit binary to 3 BCD digits, one shift per clock.
module bin2bcd_seq
   import count_display_driver_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic [BCD_W-1:0] bcd,
   output logic             busy,
   output logic             done
);

   conv_state_e       state, state_nxt;
   logic [SR_W-1:0]   sr, sr_nxt;
   logic [ITER_W-1:0] iter, iter_nxt;
   logic [BCD_W-1:0]  bcd_nxt;
   logic              busy_nxt;

   // One iteration: add 3 to every BCD nibble >= 5, then shift left.
   function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] r);
      logic [SR_W-1:0] a;
      a = r;
      for (int d = 0; d < BCD_DIGITS; d++) begin
         if (a[BIN_W + 4*d +: 4] >= 4'd5)
            a[BIN_W + 4*d +: 4] = a[BIN_W + 4*d +: 4] + 4'd3;
      end
      return {a[SR_W-2:0], 1'b0};
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (iter == ITER_W'(BIN_W - 1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      sr_nxt   = sr;
      iter_nxt = iter;
      bcd_nxt  = bcd;
      busy_nxt = busy;
      case (state)
         IDLE: begin
            if (start) begin
               sr_nxt   = {BCD_W'(0), bin};
               iter_nxt = '0;
               busy_nxt = 1'b1;
            end
         end
         SHIFT: begin
            sr_nxt   = dabble(sr);
            iter_nxt = iter + ITER_W'(1);
         end
         DONE: begin
            bcd_nxt  = sr[SR_W-1 -: BCD_W];
            busy_nxt = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr   <= '0;
         iter <= '0;
         bcd  <= '0;
         busy <= 1'b0;
      end else begin
         sr   <= sr_nxt;
         iter <= iter_nxt;
         bcd  <= bcd_nxt;
         busy <= busy_nxt;
      end
   end

   // High during the cycle the result is being committed to bcd.
   assign done = (state == DONE);

endmodule

// File: rtl/count_display_driver.sv
// Converts the counter value to BCD and scans it onto a 4-digit common-anode display.
module count_display_driver
   import count_display_driver_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 50000,
   parameter bit          BLANK_LZ = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [BIN_W-1:0]      value,
   input  logic                  ud,
   output logic [SEG_W-1:0]      seg,
   output logic [NUM_DIGITS-1:0] an,
   output logic [BCD_W-1:0]      bcd,
   output logic                  busy
);

   localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [BIN_W-1:0] last_value;
   logic             start;
   logic             armed;
   logic             done;
   logic [PRE_W-1:0] pre;
   logic [IDX_W-1:0] idx;
   logic [SEG_W-1:0] glyph_c;
   bcd_t             digits;

   // Launch a conversion when the converter is free and the value moved.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_value <= '0;
         start      <= 1'b0;
         armed      <= 1'b1;
      end else begin
         start <= 1'b0;
         if (done) begin
            armed <= 1'b1;
         end else if (armed && (value != last_value)) begin
            last_value <= value;
            start      <= 1'b1;
            armed      <= 1'b0;
         end
      end
   end

   bin2bcd_seq u_conv (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .bin   (last_value),
      .bcd   (bcd),
      .busy  (busy),
      .done  (done)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre <= '0;
         idx <= '0;
      end else if (pre == PRE_W'(SCAN_DIV - 1)) begin
         pre <= '0;
         idx <= idx + IDX_W'(1);
      end else begin
         pre <= pre + PRE_W'(1);
      end
   end

   assign digits = bcd_t'(bcd);

   // Glyph for the slot currently selected, with leading-zero blanking.
   always_comb begin
      glyph_c = GLYPH_BLANK;
      case (idx)
         2'd0: glyph_c = glyph_of(digits.ones);
         2'd1: glyph_c = (BLANK_LZ && (digits.hundreds == 4'd0) && (digits.tens == 4'd0))
                         ? GLYPH_BLANK : glyph_of(digits.tens);
         2'd2: glyph_c = (BLANK_LZ && (digits.hundreds == 4'd0))
                         ? GLYPH_BLANK : glyph_of(digits.hundreds);
         default: glyph_c = ud ? GLYPH_U : GLYPH_D;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         seg <= GLYPH_BLANK;
         an  <= '1;
      end else begin
         seg <= glyph_c;
         an  <= ~(NUM_DIGITS'(1) << idx);
      end
   end

endmodule

// File: tb/tb_count_display_driver.sv
// Randomized directed bench for count_display_driver against an arithmetic reference model.
module tb_count_display_driver;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] value = 8'd0;
   logic       ud    = 1'b1;

   logic [6:0]  seg, seg_nb;
   logic [3:0]  an, an_nb;
   logic [11:0] bcd, bcd_nb;
   logic        busy, busy_nb;

   int checks   = 0;
   int failures = 0;
   int cyc;
   int prev_v   = 0;

   localparam logic [6:0] GLYPHS [0:9] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   always #5 clk = ~clk;

   count_display_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
      .clk(clk), .reset(rst_n), .value(value), .ud(ud),
      .seg(seg), .an(an), .bcd(bcd), .busy(busy)
   );

   count_display_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
      .clk(clk), .reset(rst_n), .value(value), .ud(ud),
      .seg(seg_nb), .an(an_nb), .bcd(bcd_nb), .busy(busy_nb)
   );

   // Clock edges since the last reset release.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   function automatic logic [11:0] bcd_of(input int v);
      return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
   endfunction

   function automatic logic [6:0] seg_of(input int v, input int slot, input bit blank, input bit dir);
      int h, t, o;
      h = v / 100;
      t = (v / 10) % 10;
      o = v % 10;
      case (slot)
         0:       return GLYPHS[o];
         1:       return (blank && h == 0 && t == 0) ? 7'h7F : GLYPHS[t];
         2:       return (blank && h == 0) ? 7'h7F : GLYPHS[h];
         default: return dir ? 7'b1000001 : 7'b0100001;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive v at a negedge and follow one conversion cycle by cycle.
   task automatic convert(input int v, input bit chk_an);
      int busy_cnt;
      busy_cnt = 0;
      value = 8'(v);
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (busy === 1'b1) busy_cnt++;
         if (i == 1 && chk_an) check("an_restart", 32'(an), 32'(4'b1110));
         if (i == 2)  check("busy_rise", 32'(busy), 32'(1'b1));
         if (i == 10) check("bcd_hold", 32'(bcd), 32'(bcd_of(prev_v)));
         if (i == 11) check("bcd_new", 32'(bcd), 32'(bcd_of(v)));
      end
      check("busy_len", 32'(busy_cnt), 32'(9));
      prev_v = v;
   endtask

   task automatic scan_check(input int n, input int v);
      int slot;
      logic [3:0] one;
      logic [3:0] an_exp;
      one = 4'b0001;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         slot   = ((cyc - 1) / 4) % 4;
         an_exp = ~(one << slot);
         check("an_scan", 32'(an), 32'(an_exp));
         check("seg_blank", 32'(seg), 32'(seg_of(v, slot, 1'b1, ud)));
         check("seg_noblank", 32'(seg_nb), 32'(seg_of(v, slot, 1'b0, ud)));
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_seg", 32'(seg), 32'(7'h7F));
      check("rst_an", 32'(an), 32'(4'hF));
      check("rst_bcd", 32'(bcd), 32'(12'h000));
      check("rst_busy", 32'(busy), 32'(1'b0));
   endtask

   initial begin
      int v;

      // Reset held with a non-zero value waiting.
      rst_n = 1'b0;
      value = 8'd200;
      ud    = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      rst_n = 1'b1;
      convert(200, 1'b1);

      convert(0, 1'b0);
      convert(255, 1'b0);
      convert(9, 1'b0);

      // Change arrives during the 4th shift; reconversion follows the first result.
      value = 8'd100;
      for (int i = 1; i <= 23; i++) begin
         @(negedge clk);
         if (i == 5)  value = 8'd37;
         if (i == 11) check("mid_first", 32'(bcd), 32'(12'h100));
         if (i == 21) check("mid_hold", 32'(bcd), 32'(12'h100));
         if (i == 22) check("mid_second", 32'(bcd), 32'(12'h037));
      end
      prev_v = 37;

      for (int k = 0; k < 6; k++) begin
         v = int'($urandom_range(0, 255));
         if (v == prev_v) v = v ^ 1;
         convert(v, 1'b0);
      end

      // Scan patterns.
      convert(7, 1'b0);
      ud = 1'b1;
      scan_check(16, 7);
      ud = 1'b0;
      @(negedge clk);
      scan_check(8, 7);
      convert(50, 1'b0);
      ud = 1'b1;
      @(negedge clk);
      scan_check(16, 50);

      for (int k = 0; k < 3; k++) begin
         v = int'($urandom_range(0, 255));
         if (v == prev_v) v = v ^ 1;
         convert(v, 1'b0);
         ud = 1'($urandom_range(0, 1));
         @(negedge clk);
         scan_check(8, v);
      end

      // Reset asserted mid-shift of a conversion.
      if (prev_v == 128) convert(0, 1'b0);
      value = 8'd128;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs();
      check("rst_an_nb", 32'(an_nb), 32'(4'hF));
      @(negedge clk);
      rst_n  = 1'b1;
      prev_v = 0;
      convert(128, 1'b1);
      scan_check(8, 128);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
